// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO drain handshake and serial status bundle for the UART transmit stage
interface fifo_uart_tx_if #(parameter int DATA_WIDTH = 8);
  logic tx_enable;
  logic fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic fifo_pop;
  logic tx;
  logic busy;
  logic frame_done;
  modport master (output tx_enable, fifo_empty, fifo_data, input fifo_pop, tx, busy, frame_done);
  modport slave (input tx_enable, fifo_empty, fifo_data, output fifo_pop, tx, busy, frame_done);
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops FIFO words and serialises each as a UART frame (start, data LSB first, optional parity, stop)
module fifo_uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN = 0,
  parameter int PARITY_ODD = 0
) (
  input logic clk,
  input logic reset,
  fifo_uart_tx_if.slave bus
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [CW-1:0] bit_cnt, bit_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic par, par_n;
  logic last, on_line;
  assign last = baud == BAUD_LAST;
  assign on_line = state == START || state == DATA || state == PARITY || state == STOP;
  // next state plus baud/bit counters and shift register updates
  always_comb begin
    state_n = state;
    baud_n = (on_line && !last) ? baud + 1'b1 : '0;
    bit_n = bit_cnt;
    shift_n = shift;
    par_n = par;
    case (state)
      IDLE: state_n = (bus.tx_enable && !bus.fifo_empty) ? POP : IDLE;
      POP: state_n = LOAD;
      LOAD: begin
        shift_n = bus.fifo_data;
        par_n = ^bus.fifo_data ^ 1'(PARITY_ODD);
        state_n = START;
      end
      START: begin
        bit_n = '0;
        state_n = last ? DATA : START;
      end
      DATA: if (last) begin
        shift_n = shift >> 1;
        bit_n = bit_cnt + 1'b1;
        state_n = (bit_cnt != BIT_LAST) ? DATA : (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: state_n = last ? STOP : PARITY;
      STOP: state_n = last ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  // state/datapath registers; outputs are registered from the next-state values so they align with the state
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      shift <= '0;
      par <= 1'b0;
      bus.tx <= 1'b1;
      bus.fifo_pop <= 1'b0;
      bus.busy <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_cnt <= bit_n;
      shift <= shift_n;
      par <= par_n;
      bus.tx <= state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : state_n == PARITY ? par_n : 1'b1;
      bus.fifo_pop <= state_n == POP;
      bus.busy <= state_n != IDLE;
      bus.frame_done <= state_n == STOP && baud_n == BAUD_LAST;
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed stimulus on three parity variants, checked every cycle against a frame-level model
module tb_fifo_uart_tx;
  localparam int CPB = 4;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [7:0] log_q[$];
  always #5 clk = ~clk;
  // free-running cycle index for latency checks
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int PE = g > 0 ? 1 : 0;
    localparam int PO = g == 2 ? 1 : 0;
    localparam int FL = (DW + 2 + PE) * CPB;
    fifo_uart_tx_if #(.DATA_WIDTH(DW)) bus ();
    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(PE), .PARITY_ODD(PO)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
    );
    int head = 0;
    int pops = 0;
    int dones = 0;
    int pop_cyc = 0;
    int done_cyc = 0;
    int t = -1;
    logic [7:0] w = '0;
    assign bus.tx_enable = en;
    // FIFO with registered read data: each pop edge presents the head word on the following cycle
    always @(posedge clk)
      if (bus.fifo_pop) begin
        pops <= pops + 1;
        if (head < log_q.size()) begin
          bus.fifo_data <= log_q[head];
          head <= head + 1;
        end
      end
    // frame-level model: t counts cycles since the pop, the frame is a list of CPB-long bits
    always @(negedge clk) begin
      int k;
      logic etx, ebusy, epop, edone;
      k = (t - 2) / CPB;
      etx = 1'b1;
      ebusy = 1'b0;
      epop = 1'b0;
      edone = 1'b0;
      if (reset && t >= 0) begin
        ebusy = 1'b1;
        epop = t == 0;
        edone = t == FL + 1;
        if (t >= 2)
          etx = k == 0 ? 1'b0 : k <= DW ? w[k-1] : (PE == 1 && k == DW + 1) ? (^w ^ 1'(PO)) : 1'b1;
      end
      chk($sformatf("tx[%0d] t=%0d", g, t), bus.tx, etx);
      chk($sformatf("busy[%0d] t=%0d", g, t), bus.busy, ebusy);
      chk($sformatf("pop[%0d] t=%0d", g, t), bus.fifo_pop, epop);
      chk($sformatf("done[%0d] t=%0d", g, t), bus.frame_done, edone);
      if (bus.fifo_pop) pop_cyc = cyc;
      if (bus.frame_done) begin
        dones++;
        done_cyc = cyc;
      end
      bus.fifo_empty = head == log_q.size();
      if (!reset) t = -1;
      else if (t < 0) begin
        if (en && head < log_q.size()) begin
          t = 0;
          w = log_q[head];
        end
      end else t = (t == FL + 1) ? -1 : t + 1;
    end
  end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (n < 400 && !(u[0].bus.busy == 0 && u[1].bus.busy == 0 && u[2].bus.busy == 0 &&
           u[0].head == log_q.size() && u[1].head == log_q.size() && u[2].head == log_q.size())) begin
      tick(1);
      n++;
    end
    chk("idle_timeout", int'(n < 400), 1);
  endtask
  task automatic idle_lits(string tag);
    chk({tag, "_tx0"}, u[0].bus.tx, 1);
    chk({tag, "_tx1"}, u[1].bus.tx, 1);
    chk({tag, "_tx2"}, u[2].bus.tx, 1);
    chk({tag, "_busy0"}, u[0].bus.busy, 0);
    chk({tag, "_busy1"}, u[1].bus.busy, 0);
    chk({tag, "_busy2"}, u[2].bus.busy, 0);
    chk({tag, "_pop0"}, u[0].bus.fifo_pop, 0);
    chk({tag, "_pop1"}, u[1].bus.fifo_pop, 0);
    chk({tag, "_pop2"}, u[2].bus.fifo_pop, 0);
    chk({tag, "_done0"}, u[0].bus.frame_done, 0);
    chk({tag, "_done1"}, u[1].bus.frame_done, 0);
    chk({tag, "_done2"}, u[2].bus.frame_done, 0);
  endtask
  task automatic pop_counts(string tag, int e);
    chk({tag, "_pops0"}, u[0].pops, e);
    chk({tag, "_pops1"}, u[1].pops, e);
    chk({tag, "_pops2"}, u[2].pops, e);
  endtask
  initial begin
    logic [10:0] a5_plain, a5_even, a5_odd;
    a5_plain = 11'b11101001010;
    a5_even = 11'b10101001010;
    a5_odd = 11'b11101001010;
    tick(3);
    idle_lits("reset");
    reset = 1'b1;
    en = 1'b1;
    tick(50);
    pop_counts("empty_hold", 0);
    idle_lits("empty_hold");
    log_q.push_back(8'hA5);
    tick(1);
    chk("a5_pop0", u[0].bus.fifo_pop, 1);
    chk("a5_pop1", u[1].bus.fifo_pop, 1);
    chk("a5_pop2", u[2].bus.fifo_pop, 1);
    tick(3);
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("a5_plain_bit%0d", k), u[0].bus.tx, a5_plain[k]);
      chk($sformatf("a5_even_bit%0d", k), u[1].bus.tx, a5_even[k]);
      chk($sformatf("a5_odd_bit%0d", k), u[2].bus.tx, a5_odd[k]);
      tick(4);
    end
    wait_idle();
    chk("a5_len0", u[0].done_cyc - u[0].pop_cyc, 41);
    chk("a5_len1", u[1].done_cyc - u[1].pop_cyc, 45);
    chk("a5_len2", u[2].done_cyc - u[2].pop_cyc, 45);
    chk("a5_dones0", u[0].dones, 1);
    chk("a5_dones2", u[2].dones, 1);
    log_q.push_back(8'h00);
    log_q.push_back(8'hFF);
    log_q.push_back(8'h3C);
    wait_idle();
    pop_counts("burst", 4);
    chk("burst_dones1", u[1].dones, 4);
    log_q.push_back(8'h5A);
    log_q.push_back(8'hC3);
    tick(14);
    en = 1'b0;
    tick(80);
    pop_counts("en_drop", 5);
    chk("en_drop_pending0", u[0].head, log_q.size() - 1);
    chk("en_drop_dones0", u[0].dones, 5);
    idle_lits("en_drop");
    en = 1'b1;
    wait_idle();
    pop_counts("en_back", 6);
    log_q.push_back(8'h96);
    log_q.push_back(8'h69);
    tick(20);
    reset = 1'b0;
    #1;
    idle_lits("async_reset");
    tick(2);
    reset = 1'b1;
    wait_idle();
    pop_counts("after_reset", 8);
    chk("after_reset_dones0", u[0].dones, 7);
    chk("after_reset_dones1", u[1].dones, 7);
    chk("after_reset_dones2", u[2].dones, 7);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for the byte FIFO. It pops one word at a time while the FIFO reports non-empty and transmission is enabled. Each word is sent on a single serial line as an asynchronous UART frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit, stop bit. It is the serial egress point of the buffered data path.

Parameters:
DATA_WIDTH, 8, word width; must match the FIFO DATA_WIDTH.
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 2.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
tx_enable  input  1  level; permits starting a new frame.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  DATA_WIDTH  FIFO registered read data; valid the cycle after a pop edge.
fifo_pop  output  1  registered one-cycle pop strobe to the FIFO.
tx  output  1  serial line; idles high.
busy  output  1  high from the pop strobe through the end of the stop bit.
frame_done  output  1  registered one-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, tx=1, fifo_pop=0, busy=0, frame_done=0, bit and baud counters cleared, shift register cleared. Asserting reset mid-frame forces tx=1 immediately and abandons the frame. The popped word is lost; no re-pop.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, POP, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx=1, busy=0. If tx_enable=1 and fifo_empty=0 at an edge, go to POP.
- POP: fifo_pop=1 and busy=1 for exactly this one cycle. The next state is always LOAD.
- LOAD: capture fifo_data into the shift register and compute parity. Parity is the XOR of the data bits, inverted when PARITY_ODD=1. Go to START. fifo_pop=0.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After DATA_WIDTH bits, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx=parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. frame_done=1 in the final cycle. Then go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). Bit counter width: $clog2(DATA_WIDTH+1).
- Frame length: tx is low starting the cycle after LOAD. The frame lasts (DATA_WIDTH+2+PARITY_EN)*CLKS_PER_BIT cycles. Pop-to-start latency is 2 cycles (POP, LOAD).
- Back-to-back: after STOP the block spends one IDLE cycle, then pops again if the FIFO is still non-empty. Minimum inter-frame gap is 3 cycles of tx=1 (IDLE, POP, LOAD), in addition to the stop bit.
- tx_enable sampled only in IDLE. Deassertion mid-frame does not truncate the frame; no new pop follows.
- fifo_empty sampled only in IDLE. Changes during a frame are ignored.
- fifo_pop is never asserted while fifo_empty=1 was sampled in IDLE. It is never asserted twice per frame, so the FIFO cannot underflow.
- busy=1 in POP, LOAD, START, DATA, PARITY and STOP.

Test Plan:
- Reset check (CLKS_PER_BIT=4, DATA_WIDTH=8) -> tx=1, fifo_pop=0, busy=0, frame_done=0. Holding fifo_empty=1 with tx_enable=1 for 50 cycles -> no pop.
- Single word 0xA5, PARITY_EN=0 -> one pop pulse. Then tx emits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles). frame_done pulses once, on the 40th cycle.
- 0xA5, PARITY_EN=1: even parity -> parity bit 0; odd parity -> parity bit 1. Frame is 44 cycles.
- Three words queued (0x00, 0xFF, 0x3C) with tx_enable held high -> three pops, three frames in order. Gap between each stop-bit end and the next start bit is exactly 3 cycles. busy falls only after the third stop bit.
- tx_enable dropped during DATA of frame 1 with a second word pending -> frame 1 completes intact. No second pop until tx_enable returns high.
- reset pulsed low during bit 3 of the data bits -> tx=1 asynchronously and state=IDLE. After release, the next pending FIFO word produces a clean full frame.
